// File: rtl/board_regfile_if.sv
// rtl/board_regfile_if.sv - controller-side bus of the puzzle-board register file
interface board_regfile_if #(
   parameter int DATA_W = 18,
   parameter int ADDR_W = 6
);
   logic              init_req;
   logic              busy;
   logic [ADDR_W-1:0] src0;
   logic [ADDR_W-1:0] src1;
   logic [ADDR_W-1:0] dst;
   logic              we;
   logic [DATA_W-1:0] data;
   logic [DATA_W-1:0] outa;
   logic [DATA_W-1:0] outb;
   logic              va;
   logic              vb;
   logic              wr_err;
   logic [ADDR_W:0]   valid_cnt;

   modport master (
      output init_req, src0, src1, dst, we, data,
      input  busy, outa, outb, va, vb, wr_err, valid_cnt
   );

   modport slave (
      input  init_req, src0, src1, dst, we, data,
      output busy, outa, outb, va, vb, wr_err, valid_cnt
   );
endinterface

// File: rtl/board_regfile.sv
// rtl/board_regfile.sv - board register file with init engine, valid tracking and write bypass
module board_regfile #(
   parameter int DATA_W    = 18,
   parameter int DEPTH     = 64,
   parameter int ADDR_W    = 6,
   parameter int INIT_MODE = 1,
   parameter int BYPASS    = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   board_regfile_if.slave  bus
);
   typedef enum logic {INIT, IDLE} state_t;

   localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [ADDR_W:0]   cnt_q;
   logic              err_q;
   logic              init_start;
   logic              dst_ok;
   logic              wr_ok;
   logic [DATA_W-1:0] init_pat;

   always_comb begin
      state_d    = state_q;
      init_start = 1'b0;
      case (state_q)
         INIT: if (ptr_q == LAST_PTR) state_d = IDLE;
         IDLE: if (bus.init_req) begin
            state_d    = INIT;
            init_start = 1'b1;
         end
         default: state_d = INIT;
      endcase
   end

   // init_req takes priority over a write in the same cycle
   assign dst_ok   = {1'b0, bus.dst} < DEPTH_L;
   assign wr_ok    = (state_q == IDLE) && bus.we && !bus.init_req && dst_ok;
   assign init_pat = (INIT_MODE == 1) ? DATA_W'(ptr_q) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         ptr_q   <= '0;
         valid_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= (state_q == INIT && ptr_q != LAST_PTR) ? ptr_q + 1'b1 : '0;
         err_q   <= bus.we && !wr_ok;
         if (init_start) begin
            valid_q <= '0;
            cnt_q   <= '0;
         end else if (state_q == INIT) begin
            valid_q[ptr_q] <= 1'b0;
         end else if (wr_ok) begin
            valid_q[bus.dst] <= 1'b1;
            if (!valid_q[bus.dst] && cnt_q < DEPTH_L) cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == INIT) mem[ptr_q] <= init_pat;
      else if (wr_ok) mem[bus.dst] <= bus.data;
   end

   // returns {valid, data}; everything reads as zero while the init engine runs
   function automatic logic [DATA_W:0] rd_port(input logic [ADDR_W-1:0] a);
      rd_port = '0;
      if (state_q == IDLE && {1'b0, a} < DEPTH_L) begin
         if (BYPASS != 0 && wr_ok && bus.dst == a) rd_port = {1'b1, bus.data};
         else rd_port = {valid_q[a], mem[a]};
      end
   endfunction

   always_comb begin
      {bus.va, bus.outa} = rd_port(bus.src0);
      {bus.vb, bus.outb} = rd_port(bus.src1);
   end

   assign bus.busy      = (state_q == INIT);
   assign bus.wr_err    = err_q;
   assign bus.valid_cnt = cnt_q;
endmodule

// File: tb/tb_board_regfile.sv
// tb/tb_board_regfile.sv - directed vector bench for board_regfile
module tb_board_regfile;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        init_req = 1'b0;
   logic        we = 1'b0;
   logic [5:0]  src0 = '0, src1 = '0, dst = '0;
   logic [17:0] data = '0;
   int          total = 0;
   int          bad = 0;
   int          n, n2;

   localparam logic [17:0] D1 = 18'b000_001_010_011_100_101;
   localparam logic [17:0] D2 = 18'h15a5a;

   always #5 clk = ~clk;

   // bus[0]: DEPTH 64 bypass, bus[1]: DEPTH 64 no bypass, bus[2]: DEPTH 61 bypass
   board_regfile_if #(.DATA_W(18), .ADDR_W(6)) bus [3] ();

   for (genvar g = 0; g < 3; g++) begin : g_drv
      assign bus[g].init_req = init_req;
      assign bus[g].we       = we;
      assign bus[g].src0     = src0;
      assign bus[g].src1     = src1;
      assign bus[g].dst      = dst;
      assign bus[g].data     = data;
   end

   board_regfile #(.DATA_W(18), .DEPTH(64), .ADDR_W(6), .INIT_MODE(1), .BYPASS(1))
      u_byp (.clk(clk), .rst_n(rst_n), .bus(bus[0]));
   board_regfile #(.DATA_W(18), .DEPTH(64), .ADDR_W(6), .INIT_MODE(1), .BYPASS(0))
      u_nobyp (.clk(clk), .rst_n(rst_n), .bus(bus[1]));
   board_regfile #(.DATA_W(18), .DEPTH(61), .ADDR_W(6), .INIT_MODE(1), .BYPASS(1))
      u_d61 (.clk(clk), .rst_n(rst_n), .bus(bus[2]));

   typedef struct {
      logic        we;
      logic [5:0]  dst;
      logic [17:0] data;
      logic [5:0]  s0;
      logic [5:0]  s1;
      logic [17:0] ea;
      logic        eva;
      logic [17:0] eb;
      logic        evb;
      logic [17:0] ena;
      logic [6:0]  ecnt;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (bus[0].busy && cycles < 200) begin
         tick();
         cycles++;
      end
   endtask

   initial begin
      tbl[0] = '{1'b0, 6'd0,  18'd0,      6'd5,  6'd63, 18'd5,      1'b0, 18'd63, 1'b0, 18'd5,      7'd0};
      tbl[1] = '{1'b1, 6'd3,  D1,         6'd3,  6'd3,  D1,         1'b1, D1,     1'b1, 18'd3,      7'd1};
      tbl[2] = '{1'b0, 6'd0,  18'd0,      6'd3,  6'd4,  D1,         1'b1, 18'd4,  1'b0, D1,         7'd1};
      tbl[3] = '{1'b1, 6'd3,  D2,         6'd3,  6'd0,  D2,         1'b1, 18'd0,  1'b0, D1,         7'd1};
      tbl[4] = '{1'b1, 6'd10, 18'h3ffff,  6'd10, 6'd3,  18'h3ffff,  1'b1, D2,     1'b1, 18'd10,     7'd2};
      tbl[5] = '{1'b0, 6'd0,  18'd0,      6'd10, 6'd63, 18'h3ffff,  1'b1, 18'd63, 1'b0, 18'h3ffff,  7'd2};

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_busy",   32'(bus[0].busy), 32'd1);
      chk("reset_outa",   32'(bus[0].outa), 32'd0);
      chk("reset_va",     32'(bus[0].va), 32'd0);
      chk("reset_wr_err", 32'(bus[0].wr_err), 32'd0);
      chk("reset_cnt",    32'(bus[0].valid_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      n = 0;
      n2 = 0;
      while (bus[0].busy && n < 200) begin
         tick();
         n++;
         if (!bus[2].busy && n2 == 0) n2 = n;
      end
      chk("init_cycles_d64", 32'(n), 32'd64);
      chk("init_cycles_d61", 32'(n2), 32'd61);

      for (int i = 0; i < 6; i++) begin
         we = tbl[i].we; dst = tbl[i].dst; data = tbl[i].data;
         src0 = tbl[i].s0; src1 = tbl[i].s1;
         #2;
         chk($sformatf("v%0d_outa", i), 32'(bus[0].outa), 32'(tbl[i].ea));
         chk($sformatf("v%0d_va", i),   32'(bus[0].va),   32'(tbl[i].eva));
         chk($sformatf("v%0d_outb", i), 32'(bus[0].outb), 32'(tbl[i].eb));
         chk($sformatf("v%0d_vb", i),   32'(bus[0].vb),   32'(tbl[i].evb));
         chk($sformatf("v%0d_nobyp_outa", i), 32'(bus[1].outa), 32'(tbl[i].ena));
         tick();
         chk($sformatf("v%0d_wr_err", i), 32'(bus[0].wr_err), 32'd0);
         chk($sformatf("v%0d_cnt", i),    32'(bus[0].valid_cnt), 32'(tbl[i].ecnt));
      end
      we = 1'b0;

      // out-of-range write on the 61-entry file
      we = 1'b1; dst = 6'd62; data = 18'h1234; src0 = 6'd62; src1 = 6'd3;
      #2;
      chk("oob_outa", 32'(bus[2].outa), 32'd0);
      chk("oob_va",   32'(bus[2].va), 32'd0);
      tick();
      we = 1'b0;
      chk("oob_wr_err",  32'(bus[2].wr_err), 32'd1);
      chk("oob_cnt",     32'(bus[2].valid_cnt), 32'd2);
      chk("oob_outb",    32'(bus[2].outb), 32'(D2));
      chk("d64_62_cnt",  32'(bus[0].valid_cnt), 32'd3);
      we = 1'b1; dst = 6'd60; data = 18'h777;
      tick();
      we = 1'b0;
      chk("oob_err_pulse", 32'(bus[2].wr_err), 32'd0);
      chk("d61_last_cnt",  32'(bus[2].valid_cnt), 32'd3);

      // init_req with a concurrent write, then a write while busy
      init_req = 1'b1; we = 1'b1; dst = 6'd5; data = 18'h1;
      tick();
      init_req = 1'b0;
      chk("reinit_wr_err", 32'(bus[0].wr_err), 32'd1);
      chk("reinit_busy",   32'(bus[0].busy), 32'd1);
      chk("reinit_cnt",    32'(bus[0].valid_cnt), 32'd0);
      dst = 6'd7; src0 = 6'd3;
      #1;
      chk("busy_outa", 32'(bus[0].outa), 32'd0);
      chk("busy_va",   32'(bus[0].va), 32'd0);
      tick();
      we = 1'b0;
      chk("busy_wr_err", 32'(bus[0].wr_err), 32'd1);
      wait_idle(n);
      chk("reinit_cycles", 32'(n + 1), 32'd64);
      chk("reinit_cnt_idle", 32'(bus[0].valid_cnt), 32'd0);
      for (int i = 0; i < 64; i++) begin
         src0 = 6'(i); src1 = 6'(63 - i);
         #1;
         chk("reinit_outa", 32'(bus[0].outa), 32'(i));
         chk("reinit_va",   32'(bus[0].va), 32'd0);
         chk("reinit_outb", 32'(bus[0].outb), 32'(63 - i));
         chk("reinit_vb",   32'(bus[0].vb), 32'd0);
      end

      // fill every entry with a distinct value
      for (int i = 0; i < 64; i++) begin
         we = 1'b1; dst = 6'(i); data = 18'(i * 37 + 1000);
         tick();
      end
      we = 1'b0;
      chk("full_cnt",     32'(bus[0].valid_cnt), 32'd64);
      chk("full_cnt_d61", 32'(bus[2].valid_cnt), 32'd61);
      for (int i = 0; i < 64; i++) begin
         src0 = 6'(i); src1 = 6'((i + 17) % 64);
         #1;
         chk("full_outa", 32'(bus[0].outa), 32'(18'(i * 37 + 1000)));
         chk("full_va",   32'(bus[0].va), 32'd1);
         chk("full_outb", 32'(bus[0].outb), 32'(18'(((i + 17) % 64) * 37 + 1000)));
         chk("full_vb",   32'(bus[0].vb), 32'd1);
      end
      we = 1'b1; dst = 6'd63; data = 18'd5;
      tick();
      we = 1'b0;
      chk("rewrite_cnt",     32'(bus[0].valid_cnt), 32'd64);
      chk("d61_63_wr_err",   32'(bus[2].wr_err), 32'd1);

      // reset in idle with state, then reset mid-init at pointer 20
      rst_n = 1'b0;
      #1;
      chk("rst_idle_cnt",    32'(bus[0].valid_cnt), 32'd0);
      chk("rst_idle_busy",   32'(bus[0].busy), 32'd1);
      chk("rst_idle_wr_err", 32'(bus[2].wr_err), 32'd0);
      rst_n = 1'b1;
      repeat (20) tick();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", 32'(bus[0].busy), 32'd1);
      chk("rst_mid_outa", 32'(bus[0].outa), 32'd0);
      chk("rst_mid_cnt",  32'(bus[0].valid_cnt), 32'd0);
      #2 rst_n = 1'b1;
      wait_idle(n);
      chk("rst_mid_cycles", 32'(n), 32'd64);
      src0 = 6'd30; src1 = 6'd63;
      #1;
      chk("restore_outa", 32'(bus[0].outa), 32'd30);
      chk("restore_va",   32'(bus[0].va), 32'd0);
      chk("restore_outb", 32'(bus[0].outb), 32'd63);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/board_regfile.md
# board_regfile

Parametrised register file for puzzle-board storage: DEPTH entries of DATA_W bits, two combinational read ports, one write port. After reset, or on request, a sequential init engine loads a default pattern into every entry. Per-entry valid bits track which entries hold written (non-default) data, and a running valid count is kept. It sits between the search controller and the board datapath; the controller must respect `busy`.

## Interface
- DATA_W, 18, entry width (6 cells x 3 bits by default)
- DEPTH, 64, number of entries, 2..2^ADDR_W
- ADDR_W, 6, address width
- INIT_MODE, 1, default pattern: 0 = all zero, 1 = entry i holds i zero-extended/truncated to DATA_W
- BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to that read port
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- init_req  in  1  request re-initialisation; sampled only when idle
- busy  out  1  init engine running; writes rejected
- src0, src1  in  ADDR_W  read addresses
- dst  in  ADDR_W  write address
- we  in  1  write enable
- data  in  DATA_W  write data
- outa, outb  out  DATA_W  read data for src0 / src1
- va, vb  out  1  valid bit of entry src0 / src1
- wr_err  out  1  one-cycle pulse: the write was rejected
- valid_cnt  out  ADDR_W+1  number of valid entries

## Operation
- FSM states: INIT, IDLE. Reset forces INIT with init pointer 0, all valid bits 0, valid_cnt 0, wr_err 0.
- INIT: one entry per cycle, pointer 0..DEPTH-1, written with the INIT_MODE pattern and its valid bit cleared. After writing DEPTH-1, go to IDLE. busy=1 throughout INIT.
- IDLE, init_req=1: go to INIT with pointer 0. Clear valid bits and valid_cnt on that edge.
- IDLE, we=1, init_req=0, dst<DEPTH: entry[dst]<=data, valid[dst]<=1. valid_cnt increments only if valid[dst] was 0.
- Rejected writes drop the write and set wr_err=1 for the next cycle. A write is rejected if:
  - we=1 in INIT;
  - we=1 together with init_req=1 in IDLE (init wins); or
  - dst>=DEPTH.
- Reads are combinational:
  - outa=entry[src0], va=valid[src0]; same for the b port.
  - src>=DEPTH gives out=0, valid=0.
  - While busy=1, outa/outb=0 and va/vb=0.
- Bypass (BYPASS=1): if an accepted write targets src0 in the same cycle, outa=data and va=1. The b port behaves the same way. With BYPASS=0, reads show the old value until the next cycle.
- Both ports may read the same address. Writes never alter entries other than dst.

## Timing
- Reset values: busy=1, outa=outb=0, va=vb=0, wr_err=0, valid_cnt=0.
- Init after reset release takes DEPTH cycles. busy falls after the DEPTH-th rising edge; the first write is accepted on the edge after that.
- init_req to busy=1: next edge. Re-init also takes DEPTH cycles.
- Write latency: 1 edge. With BYPASS=1 the read sees the data in the same cycle.
- wr_err is registered: high exactly one cycle after the offending cycle.
- Reset asserted mid-init or mid-write: immediate return to the reset values, and init restarts from pointer 0 on release.
- valid_cnt reaches DEPTH at most and does not wrap.

## Test plan
- Reset, then DEPTH=64, INIT_MODE=1 -> busy high for 64 cycles. Then src0=5 gives outa=18'd5, va=0; src1=63 gives outb=18'd63; valid_cnt=0.
- In IDLE, we=1, dst=3, data=18'b000_001_010_011_100_101, src0=3:
  - BYPASS=1: outa equals data in the same cycle.
  - BYPASS=0: outa=3 that cycle, the new data next cycle.
  - Afterwards va=1 and valid_cnt=1; rewriting dst=3 leaves valid_cnt=1.
- Write during busy, or dst>=DEPTH with DEPTH=61 and dst=62 -> wr_err=1 for exactly one cycle; contents and valid_cnt unchanged.
- init_req=1 and we=1 in the same cycle -> write dropped and wr_err=1. busy=1 for 64 cycles, all va=0, valid_cnt=0, entry 3 restored to 3.
- Write all 64 entries with distinct values -> valid_cnt=64. Read every pair through both ports and match.
- Assert rst_n low at init pointer 20 -> outputs at reset values immediately. After release, a full 64-cycle init runs from pointer 0.
